// File: rtl/cr16_pkg.sv
// Shared cr16 definitions: readback FSM state encoding and the expected-sequence
// seed used by the register-file test generators.
package cr16_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_DWELL,
    ST_CHECK,
    ST_DONE
  } rb_state_t;

  localparam int unsigned FIB_SEED_A = 1;
  localparam int unsigned FIB_SEED_B = 1;

endpackage

// File: rtl/cr16_fib_gen.sv
// Registered Fibonacci pair (a, b). Load reseeds, step advances; a is the
// current expected value. Sums wrap modulo 2^DATA_WIDTH.
module cr16_fib_gen
  import cr16_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  I_CLK,
  input  logic                  I_NRESET,
  input  logic                  I_LOAD,
  input  logic                  I_STEP,
  output logic [DATA_WIDTH-1:0] O_A
);

  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;

  // NOTE: sequential state uses non-blocking assignments so a<=b and b<=a+b
  // both see the pre-edge values.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      a_q <= '0;
      b_q <= '0;
    end else if (I_LOAD) begin
      a_q <= DATA_WIDTH'(FIB_SEED_A);
      b_q <= DATA_WIDTH'(FIB_SEED_B);
    end else if (I_STEP) begin
      a_q <= b_q;
      b_q <= a_q + b_q;
    end
  end

  assign O_A = a_q;

endmodule

// File: rtl/cr16_regfile_readback_fsm.sv
// Walks datapath read port A through r0..r(NUM_REGS-1), holds each value for
// DWELL_CYCLES clocks and checks it against the Fibonacci sequence.
module cr16_regfile_readback_fsm
  import cr16_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_REGS     = 8,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                  I_CLK,
  input  logic                  I_NRESET,
  input  logic                  I_START,
  input  logic [DATA_WIDTH-1:0] I_READ_PORT_A_DATA,
  output logic [3:0]            O_READ_PORT_A_SEL,
  output logic [DATA_WIDTH-1:0] O_DISPLAY_VALUE,
  output logic                  O_BUSY,
  output logic                  O_DONE,
  output logic                  O_PASS,
  output logic [4:0]            O_ERROR_COUNT,
  output logic [3:0]            O_FAIL_INDEX
);

  localparam logic [3:0]  LAST_IDX   = 4'(NUM_REGS - 1);
  localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);
  localparam logic [4:0]  ERR_SAT    = 5'd16;

  rb_state_t             state_q, state_d;
  logic [3:0]            idx_q;
  logic [15:0]           dwell_q;
  logic                  gen_load, gen_step;
  logic [DATA_WIDTH-1:0] expected;
  logic                  start_ok;
  logic                  mismatch;

  // A start request is honoured only when no pass is running.
  assign start_ok = I_START && (state_q == ST_IDLE || state_q == ST_DONE);
  assign mismatch = (I_READ_PORT_A_DATA != expected);

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // infer a latch.
  always_comb begin
    state_d  = state_q;
    gen_load = 1'b0;
    gen_step = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (I_START) begin
          state_d  = ST_SELECT;
          gen_load = 1'b1;
        end
      end
      ST_SELECT: state_d = ST_DWELL;
      ST_DWELL:  if (dwell_q == DWELL_LAST) state_d = ST_CHECK;
      ST_CHECK: begin
        gen_step = 1'b1;
        state_d  = (idx_q == LAST_IDX) ? ST_DONE : ST_SELECT;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      idx_q   <= '0;
      dwell_q <= '0;
    end else begin
      if (start_ok)
        idx_q <= '0;
      else if (state_q == ST_CHECK && idx_q != LAST_IDX)
        idx_q <= idx_q + 4'd1;

      if (state_q == ST_SELECT)     dwell_q <= '0;
      else if (state_q == ST_DWELL) dwell_q <= dwell_q + 16'd1;
    end
  end

  cr16_fib_gen #(.DATA_WIDTH(DATA_WIDTH)) u_fib_gen (
    .I_CLK    (I_CLK),
    .I_NRESET (I_NRESET),
    .I_LOAD   (gen_load),
    .I_STEP   (gen_step),
    .O_A      (expected)
  );

  // Outputs are registered from the current state, so they trail it by a clock.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      O_READ_PORT_A_SEL <= '0;
      O_DISPLAY_VALUE   <= '0;
      O_BUSY            <= 1'b0;
      O_DONE            <= 1'b0;
      O_PASS            <= 1'b0;
      O_ERROR_COUNT     <= '0;
      O_FAIL_INDEX      <= '0;
    end else if (start_ok) begin
      O_DONE        <= 1'b0;
      O_PASS        <= 1'b0;
      O_ERROR_COUNT <= '0;
      O_FAIL_INDEX  <= '0;
    end else begin
      case (state_q)
        ST_SELECT: begin
          O_BUSY            <= 1'b1;
          O_READ_PORT_A_SEL <= idx_q;
        end
        ST_DWELL: O_BUSY <= 1'b1;
        ST_CHECK: begin
          O_BUSY          <= 1'b1;
          O_DISPLAY_VALUE <= I_READ_PORT_A_DATA;
          if (mismatch) begin
            if (O_ERROR_COUNT == '0)      O_FAIL_INDEX  <= idx_q;
            if (O_ERROR_COUNT != ERR_SAT) O_ERROR_COUNT <= O_ERROR_COUNT + 5'd1;
          end
        end
        ST_DONE: begin
          O_BUSY <= 1'b0;
          O_DONE <= 1'b1;
          O_PASS <= (O_ERROR_COUNT == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cr16_regfile_readback_fsm.sv
// Bench for cr16_regfile_readback_fsm: three parameterisations, each reading a
// register-file model, driven by a vector table plus hand-written corner cases.
module tb_cr16_regfile_readback_fsm;

  typedef struct {
    logic [3:0]  sel;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err;
    logic [3:0]  fail;
    logic [15:0] disp;
  } snap_t;

  typedef struct {
    int          idx_a;
    logic [15:0] val_a;
    int          idx_b;
    logic [15:0] val_b;
    logic        exp_pass;
    int          exp_err;
    int          exp_fail;
    logic [15:0] exp_disp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start [3];

  always #5 clk = ~clk;

  logic [15:0] rf0 [16];
  logic [15:0] rf1 [16];
  logic [7:0]  rf2 [16];

  logic [3:0]  sel0, sel1, sel2;
  logic [15:0] disp0, disp1;
  logic [7:0]  disp2;
  logic        busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
  logic [4:0]  err0, err1, err2;
  logic [3:0]  fail0, fail1, fail2;
  logic [15:0] rd0, rd1;
  logic [7:0]  rd2;

  assign rd0 = rf0[sel0];
  assign rd1 = rf1[sel1];
  assign rd2 = rf2[sel2];

  cr16_regfile_readback_fsm #(.DATA_WIDTH(16), .NUM_REGS(8), .DWELL_CYCLES(4)) dut0 (
    .I_CLK(clk), .I_NRESET(rst_n), .I_START(start[0]), .I_READ_PORT_A_DATA(rd0),
    .O_READ_PORT_A_SEL(sel0), .O_DISPLAY_VALUE(disp0), .O_BUSY(busy0), .O_DONE(done0),
    .O_PASS(pass0), .O_ERROR_COUNT(err0), .O_FAIL_INDEX(fail0));

  cr16_regfile_readback_fsm #(.DATA_WIDTH(16), .NUM_REGS(16), .DWELL_CYCLES(2)) dut1 (
    .I_CLK(clk), .I_NRESET(rst_n), .I_START(start[1]), .I_READ_PORT_A_DATA(rd1),
    .O_READ_PORT_A_SEL(sel1), .O_DISPLAY_VALUE(disp1), .O_BUSY(busy1), .O_DONE(done1),
    .O_PASS(pass1), .O_ERROR_COUNT(err1), .O_FAIL_INDEX(fail1));

  cr16_regfile_readback_fsm #(.DATA_WIDTH(8), .NUM_REGS(16), .DWELL_CYCLES(2)) dut2 (
    .I_CLK(clk), .I_NRESET(rst_n), .I_START(start[2]), .I_READ_PORT_A_DATA(rd2),
    .O_READ_PORT_A_SEL(sel2), .O_DISPLAY_VALUE(disp2), .O_BUSY(busy2), .O_DONE(done2),
    .O_PASS(pass2), .O_ERROR_COUNT(err2), .O_FAIL_INDEX(fail2));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic snap_t snap(input int u);
    snap_t s;
    case (u)
      0: s = '{sel0, busy0, done0, pass0, err0, fail0, disp0};
      1: s = '{sel1, busy1, done1, pass1, err1, fail1, disp1};
      default: s = '{sel2, busy2, done2, pass2, err2, fail2, {8'h00, disp2}};
    endcase
    return s;
  endfunction

  task automatic check_reset_values(input string tag, input int u);
    snap_t s = snap(u);
    check({tag, "_sel"},  int'(s.sel),  0);
    check({tag, "_busy"}, int'(s.busy), 0);
    check({tag, "_done"}, int'(s.done), 0);
    check({tag, "_pass"}, int'(s.pass), 0);
    check({tag, "_err"},  int'(s.err),  0);
    check({tag, "_fail"}, int'(s.fail), 0);
    check({tag, "_disp"}, int'(s.disp), 0);
  endtask

  task automatic fill_models();
    logic [15:0] a, b, t;
    a = 16'd1;
    b = 16'd1;
    for (int i = 0; i < 16; i++) begin
      rf0[i] = a;
      rf1[i] = a;
      rf2[i] = a[7:0];
      t = a + b;
      a = b;
      b = t;
    end
  endtask

  // Pulses start on unit u and follows the pass edge by edge. Edge 0 samples
  // start; BUSY/SEL appear after edge 1 and DONE after edge n_regs*(dwell+2)+1.
  // A second start pulse is raised after edge inject_k (never when -1).
  task automatic run_pass(input string tag, input int u, input int n_regs,
                          input int dwell, input int inject_k);
    snap_t s;
    int per, total, k, bad, done_k;
    per    = dwell + 2;
    total  = n_regs * per;
    bad    = 0;
    done_k = -1;
    @(negedge clk);
    start[u] = 1'b1;
    @(posedge clk);
    #1 start[u] = 1'b0;
    s = snap(u);
    check({tag, "_start_clr_done"}, int'(s.done), 0);
    check({tag, "_start_clr_err"},  int'(s.err),  0);
    check({tag, "_start_clr_fail"}, int'(s.fail), 0);
    k = 0;
    while (k < total + 20) begin
      @(posedge clk);
      k++;
      #1 s = snap(u);
      if (k == inject_k)          start[u] = 1'b1;
      else if (k == inject_k + 1) start[u] = 1'b0;
      if (s.done) begin
        done_k = k;
        break;
      end
      if (!s.busy || int'(s.sel) != (k - 1) / per) bad++;
    end
    check({tag, "_sel_walk_bad_cycles"}, bad, 0);
    check({tag, "_done_edge"}, done_k, total + 1);
    check({tag, "_busy_at_done"}, int'(s.busy), 0);
  endtask

  task automatic check_result(input string tag, input int u, input logic p,
                              input int e, input int f, input logic [15:0] d);
    snap_t s = snap(u);
    check({tag, "_pass"}, int'(s.pass), int'(p));
    check({tag, "_err"},  int'(s.err),  e);
    check({tag, "_fail"}, int'(s.fail), f);
    check({tag, "_disp"}, int'(s.disp), int'(d));
  endtask

  vec_t vecs [5];

  initial begin
    // Two register patches per pass on top of the 1,1,2,3,5,8,13,21 image.
    vecs[0] = '{0, 16'h0001, 0, 16'h0001, 1'b1, 0, 0, 16'h0015};
    vecs[1] = '{4, 16'h0006, 6, 16'h0000, 1'b0, 2, 4, 16'h0015};
    vecs[2] = '{7, 16'h0016, 7, 16'h0016, 1'b0, 1, 7, 16'h0016};
    vecs[3] = '{0, 16'h0000, 3, 16'h0003, 1'b0, 1, 0, 16'h0015};
    vecs[4] = '{1, 16'hFFFF, 2, 16'h0000, 1'b0, 2, 1, 16'h0015};

    for (int u = 0; u < 3; u++) start[u] = 1'b0;
    fill_models();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) check_reset_values($sformatf("reset_u%0d", u), u);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      fill_models();
      rf0[vecs[v].idx_a] = vecs[v].val_a;
      rf0[vecs[v].idx_b] = vecs[v].val_b;
      run_pass($sformatf("vec%0d", v), 0, 8, 4, -1);
      check_result($sformatf("vec%0d", v), 0, vecs[v].exp_pass, vecs[v].exp_err,
                   vecs[v].exp_fail, vecs[v].exp_disp);
    end

    // Restart from a failed DONE, with a stray start during the CHECK of r2
    // (edges 17..18 of the pass).
    fill_models();
    run_pass("glitch", 0, 8, 4, 2 * 6 + 4 + 1);
    check_result("glitch", 0, 1'b1, 0, 0, 16'h0015);

    // Reset while r3 is dwelling: SEL becomes 3 after edge 19 of the pass.
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1 check("pre_reset_sel_r3", int'(sel0), 3);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset", 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 check_reset_values("post_reset_idle", 0);
    run_pass("after_reset", 0, 8, 4, -1);
    check_result("after_reset", 0, 1'b1, 0, 0, 16'h0015);

    // Sixteen registers, short dwell: r15 = 987 = 0x03DB.
    run_pass("n16", 1, 16, 2, -1);
    check_result("n16", 1, 1'b1, 0, 0, 16'h03DB);
    rf1[0] = 16'h0000;
    run_pass("n16_r0bad", 1, 16, 2, -1);
    check_result("n16_r0bad", 1, 1'b0, 1, 0, 16'h03DB);

    // Eight-bit datapath: generator must wrap (r13 = 0x79, r15 = 987 mod 256 = 0xDB).
    check("w8_model_r13", int'(rf2[13]), 'h79);
    run_pass("w8", 2, 16, 2, -1);
    check_result("w8", 2, 1'b1, 0, 0, 16'h00DB);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
